// File: rtl/riscv_pkg.sv
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared fetch-side constants, state encoding and fault indices.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam logic [31:0] NOP_INST = 32'h00000013;

    typedef enum logic [0:0] {
        LOAD = 1'b0,
        RUN  = 1'b1
    } imem_state_t;

    // Bit positions inside a fetch fault vector; the trap unit decodes the same layout.
    localparam int FAULT_MISALIGN_BIT = 0;
    localparam int FAULT_RANGE_BIT    = 1;
    localparam int FAULT_W            = 2;

endpackage

`default_nettype wire

// File: rtl/inst_mem_pipe_if.sv
// ============================================================================
//  Module      : inst_mem_pipe_if
//  Description : Program-load and fetch bundle of the instruction memory.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

interface inst_mem_pipe_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic              prog_done;
    logic              prog_err;
    logic [CNT_W-1:0]  load_count;
    logic              fetch_ready;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              stall;
    logic              flush;
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_valid;
    logic              fault_misalign;
    logic              fault_range;

    modport master (
        output prog_we, prog_addr, prog_data, prog_done,
        output fetch_req, fetch_addr, stall, flush,
        input  prog_err, load_count, fetch_ready,
        input  inst, inst_addr, inst_valid, fault_misalign, fault_range
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, prog_done,
        input  fetch_req, fetch_addr, stall, flush,
        output prog_err, load_count, fetch_ready,
        output inst, inst_addr, inst_valid, fault_misalign, fault_range
    );

endinterface

`default_nettype wire

// File: rtl/imem_array.sv
// ============================================================================
//  Module      : imem_array
//  Description : DEPTH x DATA_W single-port RAM, registered read, no reset.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module imem_array
    import riscv_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  wire logic              clk,
    input  wire logic              we_i,
    input  wire logic              re_i,
    input  wire logic [IDX_W-1:0]  addr_i,
    input  wire logic [DATA_W-1:0] wdata_i,
    output      logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Read data only advances on re_i so a stalled fetch keeps its word.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/inst_mem_pipe.sv
// ============================================================================
//  Module      : inst_mem_pipe
//  Description : Loadable instruction memory with one-cycle fetch, stall/flush.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module inst_mem_pipe
    import riscv_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 64,
    parameter logic [DATA_W-1:0] NOP_INST = riscv_pkg::NOP_INST
) (
    input wire logic       clk,
    input wire logic       rst,
    inst_mem_pipe_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    // Full-width limit so upper address bits are compared, not dropped.
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(DEPTH * 4);

    imem_state_t          state_q;
    logic                 prog_err_q;
    logic [CNT_W-1:0]     load_count_q;
    logic [ADDR_W-1:0]    inst_addr_q;
    logic                 valid_q;
    logic                 sel_mem_q;
    logic [FAULT_W-1:0]   fault_q;

    logic                 w_load;
    logic                 w_run;
    logic                 w_p_bad;
    logic                 w_f_mis;
    logic                 w_f_rng;
    logic                 w_prog_wr;
    logic                 w_ram_re;
    logic [IDX_W-1:0]     w_ram_addr;
    logic [DATA_W-1:0]    w_rdata;

    always_comb begin
        w_load     = (state_q == LOAD);
        w_run      = (state_q == RUN);
        w_p_bad    = (bus.prog_addr[1:0] != 2'b00) ||
                     ({1'b0, bus.prog_addr} >= ADDR_LIMIT);
        w_f_mis    = (bus.fetch_addr[1:0] != 2'b00);
        w_f_rng    = ({1'b0, bus.fetch_addr} >= ADDR_LIMIT);
        w_prog_wr  = w_load && bus.prog_we && !w_p_bad;
        w_ram_re   = w_run && !bus.flush && !bus.stall && bus.fetch_req &&
                     !w_f_mis && !w_f_rng;
        // Writes and reads never overlap, so one port is shared by phase.
        w_ram_addr = w_load ? bus.prog_addr[IDX_W+1:2] : bus.fetch_addr[IDX_W+1:2];
    end

    imem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .we_i    (w_prog_wr),
        .re_i    (w_ram_re),
        .addr_i  (w_ram_addr),
        .wdata_i (bus.prog_data),
        .rdata_o (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LOAD;
            prog_err_q   <= 1'b0;
            load_count_q <= '0;
            inst_addr_q  <= '0;
            valid_q      <= 1'b0;
            sel_mem_q    <= 1'b0;
            fault_q      <= '0;
        end else begin
            prog_err_q <= bus.prog_we && (w_run || w_p_bad);
            case (state_q)
                LOAD: begin
                    valid_q   <= 1'b0;
                    sel_mem_q <= 1'b0;
                    fault_q   <= '0;
                    if (w_prog_wr && (load_count_q != CNT_W'(DEPTH))) begin
                        load_count_q <= load_count_q + 1'b1;
                    end
                    if (bus.prog_done) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (bus.flush) begin
                        valid_q   <= 1'b0;
                        sel_mem_q <= 1'b0;
                        fault_q   <= '0;
                    end else if (bus.stall) begin
                        valid_q   <= valid_q;
                    end else if (bus.fetch_req) begin
                        inst_addr_q                 <= bus.fetch_addr;
                        valid_q                     <= 1'b1;
                        sel_mem_q                   <= !w_f_mis && !w_f_rng;
                        fault_q[FAULT_MISALIGN_BIT] <= w_f_mis;
                        fault_q[FAULT_RANGE_BIT]    <= w_f_rng && !w_f_mis;
                    end else begin
                        valid_q   <= 1'b0;
                        sel_mem_q <= 1'b0;
                        fault_q   <= '0;
                    end
                end
                default: begin
                    state_q <= LOAD;
                end
            endcase
        end
    end

    assign bus.prog_err       = prog_err_q;
    assign bus.load_count     = load_count_q;
    assign bus.fetch_ready    = (state_q == RUN);
    assign bus.inst           = sel_mem_q ? w_rdata : NOP_INST;
    assign bus.inst_addr      = inst_addr_q;
    assign bus.inst_valid     = valid_q;
    assign bus.fault_misalign = fault_q[FAULT_MISALIGN_BIT];
    assign bus.fault_range    = fault_q[FAULT_RANGE_BIT];

endmodule

`default_nettype wire

// File: tb/tb_inst_mem_pipe.sv
// ============================================================================
//  Module      : tb_inst_mem_pipe
//  Description : Directed self-checking bench for inst_mem_pipe.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_inst_mem_pipe;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [31:0] W0  = 32'h00002083;
    localparam logic [31:0] W1  = 32'h00402103;
    localparam logic [31:0] W2  = 32'h00802183;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    inst_mem_pipe_if #(.ADDR_W(32), .DATA_W(32), .DEPTH(64)) bus ();

    inst_mem_pipe #(.ADDR_W(32), .DATA_W(32), .DEPTH(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // {valid, misalign, range, inst_addr, inst}
    logic [66:0] res;
    assign res = {bus.inst_valid, bus.fault_misalign, bus.fault_range, bus.inst_addr, bus.inst};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = pc;
        tick();
        bus.fetch_req  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_total++;
        if (res !== {3'b000, 32'h0, NOP}) $display("FAIL reset_outputs act=%h exp=%h", res, {3'b000, 32'h0, NOP});
        else n_pass++;
        n_total++;
        if ({bus.prog_err, bus.fetch_ready, bus.load_count} !== 9'd0)
            $display("FAIL reset_ctrl act=%h exp=0", {bus.prog_err, bus.fetch_ready, bus.load_count});
        else n_pass++;
    endtask

    task automatic test_load();
        logic [31:0] words [3];
        words[0] = W0; words[1] = W1; words[2] = W2;
        for (int i = 0; i < 3; i++) begin
            bus.prog_we   = 1'b1;
            bus.prog_addr = 32'(i * 4);
            bus.prog_data = words[i];
            tick();
        end
        bus.prog_we = 1'b0;
        n_total++;
        if (bus.load_count !== 7'd3) $display("FAIL load_count act=%0d exp=3", bus.load_count);
        else n_pass++;
        fetch(32'h0);
        n_total++;
        if (bus.inst_valid !== 1'b0) $display("FAIL load_fetch_ignored act=%b exp=0", bus.inst_valid);
        else n_pass++;
        bus.prog_done = 1'b1;
        n_total++;
        if (bus.fetch_ready !== 1'b0) $display("FAIL ready_before_done act=%b exp=0", bus.fetch_ready);
        else n_pass++;
        tick();
        bus.prog_done = 1'b0;
        tick();
        n_total++;
        if (bus.fetch_ready !== 1'b1) $display("FAIL ready_after_done act=%b exp=1", bus.fetch_ready);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [3];
        words[0] = W0; words[1] = W1; words[2] = W2;
        for (int i = 0; i < 3; i++) begin
            bus.fetch_req  = 1'b1;
            bus.fetch_addr = 32'(i * 4);
            tick();
            n_total++;
            if (res !== {3'b100, 32'(i * 4), words[i]})
                $display("FAIL b2b_fetch%0d act=%h exp=%h", i, res, {3'b100, 32'(i * 4), words[i]});
            else n_pass++;
        end
        bus.fetch_req = 1'b0;
        tick();
        n_total++;
        if ({res[66:64], res[31:0]} !== {3'b000, NOP}) $display("FAIL idle_nop act=%h exp=%h", {res[66:64], res[31:0]}, {3'b000, NOP});
        else n_pass++;
    endtask

    task automatic test_stall();
        fetch(32'h4);
        bus.stall     = 1'b1;
        bus.fetch_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.fetch_addr = 32'(8 - 4 * (i % 2) * 2);
            tick();
            n_total++;
            if (res !== {3'b100, 32'h4, W1}) $display("FAIL stall_hold%0d act=%h exp=%h", i, res, {3'b100, 32'h4, W1});
            else n_pass++;
        end
        bus.stall      = 1'b0;
        bus.fetch_addr = 32'h8;
        tick();
        bus.fetch_req  = 1'b0;
        n_total++;
        if (res !== {3'b100, 32'h8, W2}) $display("FAIL stall_release act=%h exp=%h", res, {3'b100, 32'h8, W2});
        else n_pass++;
    endtask

    task automatic test_faults();
        logic [31:0] pcs  [5];
        logic [2:0]  flag [5];
        pcs[0] = 32'h6;        flag[0] = 3'b110;
        pcs[1] = 32'h100;      flag[1] = 3'b101;
        pcs[2] = 32'h102;      flag[2] = 3'b110;
        pcs[3] = 32'h8000_0000; flag[3] = 3'b101;
        pcs[4] = 32'h104;      flag[4] = 3'b101;
        for (int i = 0; i < 5; i++) begin
            fetch(pcs[i]);
            n_total++;
            if (res !== {flag[i], pcs[i], NOP}) $display("FAIL fault%0d act=%h exp=%h", i, res, {flag[i], pcs[i], NOP});
            else n_pass++;
        end
        fetch(32'hFC);
        n_total++;
        if (res[66:32] !== {3'b100, 32'hFC}) $display("FAIL last_word_ok act=%h exp=%h", res[66:32], {3'b100, 32'hFC});
        else n_pass++;
    endtask

    task automatic test_flush();
        fetch(32'h4);
        bus.flush      = 1'b1;
        bus.stall      = 1'b1;
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'h8;
        tick();
        bus.flush      = 1'b0;
        bus.stall      = 1'b0;
        bus.fetch_req  = 1'b0;
        n_total++;
        if ({res[66:64], res[31:0]} !== {3'b000, NOP}) $display("FAIL flush_squash act=%h exp=%h", {res[66:64], res[31:0]}, {3'b000, NOP});
        else n_pass++;
        fetch(32'h8);
        n_total++;
        if (res !== {3'b100, 32'h8, W2}) $display("FAIL after_flush act=%h exp=%h", res, {3'b100, 32'h8, W2});
        else n_pass++;
    endtask

    task automatic test_prog_err();
        bus.prog_we   = 1'b1;
        bus.prog_addr = 32'h0;
        bus.prog_data = 32'hDEADBEEF;
        tick();
        bus.prog_we   = 1'b0;
        n_total++;
        if ({bus.prog_err, bus.load_count} !== {1'b1, 7'd3}) $display("FAIL run_prog_err act=%h exp=%h", {bus.prog_err, bus.load_count}, {1'b1, 7'd3});
        else n_pass++;
        tick();
        n_total++;
        if (bus.prog_err !== 1'b0) $display("FAIL prog_err_pulse act=%b exp=0", bus.prog_err);
        else n_pass++;
        fetch(32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_total++;
        if ({bus.fetch_ready, bus.load_count, res[66:64], res[31:0]} !== {1'b0, 7'd0, 3'b000, NOP})
            $display("FAIL reset_mid_run act=%h exp=%h", {bus.fetch_ready, bus.load_count, res[66:64], res[31:0]}, {1'b0, 7'd0, 3'b000, NOP});
        else n_pass++;
        bus.prog_we   = 1'b1;
        bus.prog_addr = 32'h3;
        bus.prog_data = 32'h12345678;
        tick();
        bus.prog_we   = 1'b0;
        n_total++;
        if ({bus.prog_err, bus.load_count} !== {1'b1, 7'd0}) $display("FAIL load_bad_addr act=%h exp=%h", {bus.prog_err, bus.load_count}, {1'b1, 7'd0});
        else n_pass++;
        bus.prog_done = 1'b1;
        tick();
        bus.prog_done = 1'b0;
        fetch(32'h0);
        n_total++;
        if (res !== {3'b100, 32'h0, W0}) $display("FAIL mem_retained act=%h exp=%h", res, {3'b100, 32'h0, W0});
        else n_pass++;
    endtask

    initial begin
        bus.prog_we    = 1'b0;
        bus.prog_addr  = '0;
        bus.prog_data  = '0;
        bus.prog_done  = 1'b0;
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = '0;
        bus.stall      = 1'b0;
        bus.flush      = 1'b0;
        test_reset();
        test_load();
        test_back_to_back();
        test_stall();
        test_faults();
        test_flush();
        test_prog_err();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/inst_mem_pipe.md
Name: inst_mem_pipe

Overview:
Parametrised, synchronously-read instruction memory that replaces the fixed 64-word combinational instruction store in the fetch stage. It has a program-load phase, in which a loader writes words through a dedicated port, followed by a run phase. In the run phase it serves fetches with one-cycle latency and supports stall and flush from the pipeline hazard logic. Misaligned and out-of-range fetches are flagged and return a NOP instead of undefined data.

Parameters:
ADDR_W, 32, byte-address width of fetch and program ports
DATA_W, 32, instruction word width
DEPTH, 64, number of words; power of two, at least 4
NOP_INST, 32'h00000013, word returned on fault, flush and reset (addi x0,x0,0)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
prog_we  in  1  load-port write strobe
prog_addr  in  ADDR_W  load-port byte address
prog_data  in  DATA_W  load-port word
prog_done  in  1  loader finished; moves block to RUN
prog_err  out  1  one-cycle pulse: rejected load write
load_count  out  clog2(DEPTH)+1  number of accepted load writes since reset
fetch_ready  out  1  high only in RUN
fetch_req  in  1  fetch request
fetch_addr  in  ADDR_W  PC (byte address)
stall  in  1  hold all fetch outputs
flush  in  1  squash the in-flight fetch
inst  out  DATA_W  fetched instruction
inst_addr  out  ADDR_W  PC of the word on inst
inst_valid  out  1  inst holds a valid fetch result
fault_misalign  out  1  fetch_addr[1:0] was nonzero
fault_range  out  1  fetch_addr was >= DEPTH*4

Behaviour:
- Word index = addr[clog2(DEPTH)+1:2]. An address is "bad" if addr[1:0]!=0 or addr >= DEPTH*4.
- Reset values: state=LOAD, inst=NOP_INST, inst_addr=0, inst_valid=0, both faults=0, prog_err=0, load_count=0, fetch_ready=0.
- Reset does not clear array contents. A reset mid-run returns the block to LOAD and drops any in-flight fetch.
- State machine has two states, LOAD and RUN. LOAD goes to RUN on the cycle after prog_done=1. RUN leaves only on rst.
- LOAD, prog_we with a good address: mem[index] <= prog_data; load_count increments, saturating at DEPTH.
- LOAD, prog_we with a bad address: no write; prog_err=1 on the next cycle.
- LOAD, prog_we and prog_done in the same cycle: the write is performed, then the block enters RUN.
- LOAD, fetch_req: ignored. inst_valid stays 0.
- RUN, prog_we: ignored; prog_err pulses.
- RUN fetch: one-cycle latency. Priority is flush > stall > fetch_req.
  - flush=1: next cycle inst_valid=0, inst=NOP_INST, faults=0.
  - stall=1 without flush: every fetch output holds its value; fetch_req is not sampled.
  - fetch_req=1: next cycle inst_addr=fetch_addr, inst_valid=1, and inst=mem[index] (good address) or NOP_INST (bad address). The matching fault bit is set; fault_misalign takes precedence if both conditions hold.
  - fetch_req=0: next cycle inst_valid=0, inst=NOP_INST, faults=0.
- Back-to-back fetches give one result per cycle. The block has no internal queue.
- Read during a write to the same index cannot occur, because writes happen only in LOAD and reads only in RUN.
- Address width arithmetic is unsigned. Upper address bits are compared, never truncated, for the range check.

Decomposition:
- Shared package riscv_pkg holds:
  - NOP_INST constant
  - imem_state_t enum {LOAD, RUN}
  - fault-bit index constants, reused by the trap unit
- One sub-module, imem_array: a DEPTH x DATA_W single-port synchronous RAM with registered read and write enable, so it infers block RAM.
- The FSM, address checks and output registers stay in inst_mem_pipe.

Test Plan:
1. Reset, then load words 0x00002083, 0x00402103, 0x00802183 at addresses 0, 4, 8, then prog_done -> load_count=3, fetch_ready=1 on the second cycle after prog_done.
2. RUN, fetch_req with PCs 0, 4, 8 on consecutive cycles -> inst equals those three words one cycle later each, inst_valid=1, inst_addr matches.
3. Fetch PC 4, then stall=1 for 3 cycles with PC changing -> inst=0x00402103 and inst_addr=4 held throughout; the next PC is served after stall drops.
4. Fetch 0x6 -> inst=NOP_INST, fault_misalign=1. Fetch 0x100 with DEPTH=64 -> NOP_INST, fault_range=1. Fetch 0x102 -> fault_misalign=1 only.
5. flush and stall asserted together with fetch_req at PC 8 -> next cycle inst_valid=0, inst=NOP_INST.
6. In LOAD, prog_we at 0x3 -> prog_err pulse and load_count unchanged. In RUN, prog_we -> prog_err and memory unchanged. rst mid-run -> LOAD, fetch_ready=0, PC 0 returns its old word after prog_done.
